// File: rtl/fp_normalizer.sv
// Post-add normalization stage for single-precision results: one shift per cycle, valid/ready on both sides.
// Define FP_NORM_ROUND_EN to round-half-to-even on right shifts; otherwise right shifts truncate.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exponent,
  input  logic [24:0] in_mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        zero,
  output logic [4:0]  shift_count
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state;
  logic        sign_q;
  logic [8:0]  exp_q;
  logic [24:0] mant_q;
  logic [24:0] mant_rs;

`ifdef FP_NORM_ROUND_EN
  // Guard bit is the dropped LSB; mant_q[1] becomes the new LSB. Cannot overflow 25 bits.
  always_comb mant_rs = (mant_q >> 1) + {24'd0, mant_q[0] & mant_q[1]};
`else
  always_comb mant_rs = mant_q >> 1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      zero        <= 1'b0;
      shift_count <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_q      <= in_sign;
            exp_q       <= {1'b0, in_exponent};
            mant_q      <= in_mantissa;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            zero        <= 1'b0;
            shift_count <= '0;
            in_ready    <= 1'b0;
            state       <= NORM;
          end else begin
            in_ready <= 1'b1;
          end
        end
        NORM: begin
          if (mant_q == '0) begin
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_q == 9'd255) begin
            result    <= {sign_q, 8'hFF, 23'h0};
            overflow  <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mant_q[24]) begin
            mant_q      <= mant_rs;
            exp_q       <= exp_q + 9'd1;
            shift_count <= shift_count + 5'd1;
          end else if (!mant_q[23] && exp_q <= 9'd1) begin
            result    <= {sign_q, 31'h0};
            underflow <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (!mant_q[23]) begin
            mant_q      <= mant_q << 1;
            exp_q       <= exp_q - 9'd1;
            shift_count <= shift_count + 5'd1;
          end else begin
            result    <= {sign_q, exp_q[7:0], mant_q[22:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed cases plus randomized operations against an arithmetic model.
module tb_fp_normalizer;

`ifdef FP_NORM_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [24:0] in_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        zero;
  logic [4:0]  shift_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_result;
  int          last_lat;

  fp_normalizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exponent(in_exponent),
    .in_mantissa(in_mantissa),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow),
    .zero       (zero),
    .shift_count(shift_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Computes the outcome from the value itself: carries are shifted out first,
  // then the leading-one distance decides between a normal result and underflow.
  task automatic ref_model(input bit s, input int e, input int m,
                           output logic [31:0] r, output bit ov, output bit un,
                           output bit zr, output int n);
    int mm, ee, msb, k;
    logic [31:0] frac;
    logic [31:0] ebits;
    mm = m; ee = e; ov = 0; un = 0; zr = 0; n = 0;
    if (mm == 0) begin
      r = '0; zr = 1; return;
    end
    forever begin
      if (ee == 255) begin
        r = {s, 8'hFF, 23'h0}; ov = 1; return;
      end
      if (mm < (1 << 24)) break;
      mm = (mm / 2) + ((ROUND_EN && (mm % 2 == 1) && ((mm / 2) % 2 == 1)) ? 1 : 0);
      ee++; n++;
    end
    msb = 0;
    for (int i = 0; i < 25; i++) if ((mm >> i) & 1) msb = i;
    k = 23 - msb;
    if (k == 0 || k <= ee - 1) begin
      n += k;
      frac  = mm << k;
      ebits = ee - k;
      r = {s, ebits[7:0], frac[22:0]};
    end else begin
      n += (ee > 1) ? ee - 1 : 0;
      r = {s, 31'h0};
      un = 1;
    end
  endtask

  task automatic run_op(input bit s, input logic [7:0] e, input logic [24:0] m, input int hold);
    logic [31:0] r;
    bit ov, un, zr;
    int n, guard, lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    ref_model(s, int'(e), int'(m), r, ov, un, zr, n);
    in_sign = s; in_exponent = e; in_mantissa = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    check("latency", lat, n + 1);
    if (!out_valid) return;
    last_result = result;
    last_lat    = lat;
    check("result", result, r);
    check("flags", {29'd0, overflow, underflow, zero}, {29'd0, ov, un, zr});
    check("shift_count", 32'(shift_count), n);
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_mantissa = 25'($urandom); in_exponent = 8'($urandom);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_result", result, r);
      check("hold_flags", {26'd0, overflow, underflow, zero, shift_count},
            {26'd0, ov, un, zr, 5'(n)});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handshake_valid", {31'd0, out_valid}, 32'd0);
    check("handshake_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  e;
    logic [24:0] m;
    int k;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0;
    in_mantissa = '0; out_ready = 1'b0;
    #1;
    check("reset_outputs", {in_ready, out_valid, overflow, underflow, zero, shift_count} , 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {31'd0, in_ready}, 32'd1);

    run_op(1'b0, 8'h80, 25'h1800000, 0);
    check("dir1_result", last_result, 32'h40C00000);
    check("dir1_latency", last_lat, 2);
    run_op(1'b0, 8'h80, 25'h0000001, 0);
    check("dir2_result", last_result, 32'h34800000);
    check("dir2_latency", last_lat, 24);
    run_op(1'b1, 8'h37, 25'h0000000, 0);
    check("dir3_result", last_result, 32'h00000000);
    check("dir3_latency", last_lat, 1);
    run_op(1'b1, 8'h01, 25'h0400000, 0);
    check("dir4_result", last_result, 32'h80000000);
    run_op(1'b0, 8'hFE, 25'h1000000, 0);
    check("dir5_result", last_result, 32'h7F800000);
    run_op(1'b0, 8'h80, 25'h1800003, 0);
    check("dir6_result", last_result, ROUND_EN ? 32'h40C00002 : 32'h40C00001);
    run_op(1'b1, 8'h90, 25'h0123456, 5);

    // Asynchronous reset while an operation is in flight
    in_sign = 1'b0; in_exponent = 8'h80; in_mantissa = 25'h1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midnorm_reset_outputs", {in_ready, out_valid, overflow, underflow, zero, shift_count}, 32'd0);
    check("midnorm_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 8'h80, 25'h1800000, 0);
    check("post_reset_result", last_result, 32'h40C00000);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: e = 8'h00;
        1: e = 8'h01;
        2: e = 8'h02;
        3: e = 8'hFE;
        4: e = 8'hFF;
        default: e = 8'($urandom);
      endcase
      k = $urandom_range(0, 25);
      if (k == 0) m = '0;
      else m = 25'(($urandom & ((1 << k) - 1)) | (1 << (k - 1)));
      run_op(1'($urandom), e, m, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
